svc_rv_dmem_responder: RTL and testbench
========================================

// Module: svc_rv_dmem_responder
//
// PURPOSE
// - Responder end of the svc_rv data-memory interface. It answers core dmem reads and writes from internal word storage.
// - It inserts bounded, deterministic stalls to mimic cache misses.
// - Used in SoC simulation and benches as the data memory for pipelined svc_rv, with SRAM or BRAM read timing.
//
// PARAMETERS
// - AW           10  word-address bits; storage is 2**AW x 32.
// - MEM_TYPE     0   read timing: 0 = SRAM (combinational), 1 = BRAM (registered, 1 cycle).
// - STALL_CYCLES 2   stall length per miss, in cycles; legal range 1..3.
// - MISS_PERIOD  4   every MISS_PERIOD-th accepted read is a miss; 0 = never stall.
//
// PORTS
// - clock             in   1   clock
// - reset             in   1   synchronous, active-high reset
// - dmem_ren          in   1   read request
// - dmem_raddr        in   32  read byte address
// - dmem_rdata        out  32  read data
// - dmem_we           in   1   write request
// - dmem_waddr        in   32  write byte address
// - dmem_wdata        in   32  write data
// - dmem_wstrb        in   4   byte write enables; bit i enables byte i
// - dmem_stall        out  1   stall to core; core holds its requests while high
// - stat_reads        out  32  accepted-read count (optional feature)
// - stat_stall_cycles out  32  cycles with dmem_stall high (optional feature)
//
// BEHAVIOUR
// - Indexing: word index = addr[AW+1:2]. Bits [1:0] are ignored. Bits above AW+1 are ignored, so addresses wrap.
// - Writes: applied at the posedge when dmem_we=1, per-byte by dmem_wstrb, including during stall.
//   A re-issued write is idempotent. wstrb=0 leaves the word unchanged.
// - Read/write collision: same word read and written in one cycle returns the OLD data (read-first), in both MEM_TYPEs.
// - A read is accepted when dmem_ren=1 and dmem_stall=0. Reads presented while dmem_stall=1 are ignored.
// - MEM_TYPE=0 (SRAM):
//   - dmem_rdata = mem[idx] combinationally while a read is accepted.
//   - Otherwise dmem_rdata = last accepted read data (held register).
// - MEM_TYPE=1 (BRAM):
//   - dmem_rdata register loads mem[idx] at the posedge of an accepted read.
//   - It holds in all other cycles.
// - Miss counter: miss_cnt (width clog2(MISS_PERIOD)) increments on each accepted read and wraps at MISS_PERIOD-1.
//   - A read accepted while miss_cnt==MISS_PERIOD-1 is a miss.
// - FSM:
//   - IDLE: dmem_stall=0. On an accepted miss read -> STALL, with stall_left=STALL_CYCLES-1.
//   - STALL: dmem_stall=1. dmem_rdata holds the data captured for the missed read. Next state:
//     - stall_left==0 -> IDLE.
//     - otherwise decrement stall_left and stay in STALL.
//   - Result: dmem_stall is high for exactly STALL_CYCLES consecutive cycles, starting the cycle after the miss read.
//   - dmem_stall is never high without a preceding accepted read (pending-read rule).
// - MISS_PERIOD=0: the FSM stays in IDLE and dmem_stall is constant 0.
// - Reset values:
//   - dmem_stall=0, dmem_rdata=0 (held/registered value), FSM=IDLE, miss_cnt=0, stats=0.
//   - Memory contents are not reset.
// - Reset mid-stall: dmem_stall=0 from the cycle after the reset edge. A pending miss is dropped.
// - Simultaneous read+write to different words: both served in the same cycle.
//
// CONFIGURATION
// - SVC_RV_DMEM_RESP_STATS_EN defined:
//   - stat_reads increments on each accepted read.
//   - stat_stall_cycles increments on each cycle with dmem_stall=1.
//   - Both saturate at 32'hFFFF_FFFF and clear on reset.
// - SVC_RV_DMEM_RESP_STATS_EN undefined: both stat outputs are tied to 0 and no counter logic is built.
//
// TESTING
// 1. Write 0xDEADBEEF with wstrb=4'hF to 0x10, then read 0x10:
//    SRAM -> rdata 0xDEADBEEF the same cycle; BRAM -> rdata 0xDEADBEEF the next cycle.
// 2. Byte strobes: word 0x20 = 0x11223344, write 0xAABBCCDD with wstrb=4'b0101, read 0x20 -> 0x11BB33DD.
// 3. MISS_PERIOD=4, STALL_CYCLES=2, four back-to-back reads:
//    4th read -> stall=1 for exactly 2 cycles after it; rdata holds 4th-read data; reads offered during the stall are ignored.
// 4. Wrap/alias, AW=10: write 0x5A to 0x0000_0004, read 0x0000_1004 -> 0x5A. Read 0x0000_0007 -> same word.
// 5. Reset in the 1st stall cycle -> stall=0 and rdata=0 next cycle; the next 3 reads do not stall (miss_cnt=0).
// 6. STATS_EN defined, scenario 3 -> stat_reads=4, stat_stall_cycles=2. STATS_EN undefined -> both outputs read 0.

Source files
------------

// File: rtl/svc_rv_dmem_responder_if.sv
// rtl/svc_rv_dmem_responder_if.sv - svc_rv data-memory bus between core (master) and responder (slave)
interface svc_rv_dmem_responder_if;
   logic        dmem_ren;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_rdata;
   logic        dmem_we;
   logic [31:0] dmem_waddr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_stall;

   modport master (
      output dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      input  dmem_rdata, dmem_stall
   );

   modport slave (
      input  dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      output dmem_rdata, dmem_stall
   );
endinterface

// File: rtl/svc_rv_dmem_responder.sv
// rtl/svc_rv_dmem_responder.sv - svc_rv dmem responder with word storage and periodic miss stalls
// Optional read/stall statistics counters built when SVC_RV_DMEM_RESP_STATS_EN is defined.
module svc_rv_dmem_responder #(
   parameter int AW           = 10,
   parameter int MEM_TYPE     = 0,
   parameter int STALL_CYCLES = 2,
   parameter int MISS_PERIOD  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   svc_rv_dmem_responder_if.slave dmem,
   output logic [31:0]           stat_reads,
   output logic [31:0]           stat_stall_cycles
);

   localparam int CW = (MISS_PERIOD > 1) ? $clog2(MISS_PERIOD) : 1;
   localparam logic [CW-1:0] MISS_LAST  = (MISS_PERIOD > 1) ? CW'(MISS_PERIOD - 1) : '0;
   localparam logic [1:0]    STALL_INIT = 2'(STALL_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_STALL
   } state_e;

   logic [31:0]   mem [2**AW];
   logic [AW-1:0] ridx;
   logic [AW-1:0] widx;
   logic [31:0]   mem_rword;
   logic          rd_accept;
   logic          is_miss;
   logic          stall_w;

   state_e        state_q, state_d;
   logic [1:0]    stall_left_q, stall_left_d;
   logic [CW-1:0] miss_cnt_q, miss_cnt_d;
   logic [31:0]   rdata_q, rdata_d;

   assign ridx      = dmem.dmem_raddr[AW+1:2];
   assign widx      = dmem.dmem_waddr[AW+1:2];
   assign mem_rword = mem[ridx];
   assign stall_w   = (state_q == S_STALL);
   assign rd_accept = dmem.dmem_ren && !stall_w;
   assign is_miss   = rd_accept && (MISS_PERIOD != 0) && (miss_cnt_q == MISS_LAST);

   // Address bits outside the word index are deliberately ignored so addresses alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{dmem.dmem_raddr[31:AW+2], dmem.dmem_raddr[1:0],
                               dmem.dmem_waddr[31:AW+2], dmem.dmem_waddr[1:0]};

   // Storage is not reset; the read above sees pre-edge contents, giving read-first collisions.
   always_ff @(posedge clock) begin
      if (dmem.dmem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem.dmem_wstrb[b]) begin
               mem[widx][8*b +: 8] <= dmem.dmem_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      stall_left_d = stall_left_q;
      miss_cnt_d   = miss_cnt_q;
      rdata_d      = rdata_q;

      if (rd_accept) begin
         rdata_d = mem_rword;
         if (MISS_PERIOD != 0) begin
            miss_cnt_d = (miss_cnt_q == MISS_LAST) ? '0 : miss_cnt_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (is_miss) begin
               state_d      = S_STALL;
               stall_left_d = STALL_INIT;
            end
         end
         S_STALL: begin
            if (stall_left_q == 2'd0) begin
               state_d = S_IDLE;
            end else begin
               stall_left_d = stall_left_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         stall_left_q <= 2'd0;
         miss_cnt_q   <= '0;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         stall_left_q <= stall_left_d;
         miss_cnt_q   <= miss_cnt_d;
         rdata_q      <= rdata_d;
      end
   end

   generate
      if (MEM_TYPE == 0) begin : gen_sram
         assign dmem.dmem_rdata = rd_accept ? mem_rword : rdata_q;
      end else begin : gen_bram
         assign dmem.dmem_rdata = rdata_q;
      end
   endgenerate

   assign dmem.dmem_stall = stall_w;

`ifdef SVC_RV_DMEM_RESP_STATS_EN
   logic [31:0] stat_reads_q, stat_reads_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_reads_d = stat_reads_q;
      stat_stall_d = stat_stall_q;
      if (rd_accept && (stat_reads_q != 32'hFFFF_FFFF)) begin
         stat_reads_d = stat_reads_q + 32'd1;
      end
      if (stall_w && (stat_stall_q != 32'hFFFF_FFFF)) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_reads_q <= 32'd0;
         stat_stall_q <= 32'd0;
      end else begin
         stat_reads_q <= stat_reads_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_reads        = stat_reads_q;
   assign stat_stall_cycles = stat_stall_q;
`else
   assign stat_reads        = 32'd0;
   assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_svc_rv_dmem_responder.sv
// tb/tb_svc_rv_dmem_responder.sv - directed bench for SRAM, BRAM and never-miss responder builds
module tb_svc_rv_dmem_responder;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

`ifdef SVC_RV_DMEM_RESP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   svc_rv_dmem_responder_if if_s ();
   svc_rv_dmem_responder_if if_b ();
   svc_rv_dmem_responder_if if_z ();

   logic [31:0] st_rd_s, st_sc_s, st_rd_b, st_sc_b, st_rd_z, st_sc_z;

   svc_rv_dmem_responder #(.AW(10), .MEM_TYPE(0), .STALL_CYCLES(2), .MISS_PERIOD(4)) dut_s (
      .clock(clock), .reset(reset), .dmem(if_s),
      .stat_reads(st_rd_s), .stat_stall_cycles(st_sc_s)
   );
   svc_rv_dmem_responder #(.AW(10), .MEM_TYPE(1), .STALL_CYCLES(2), .MISS_PERIOD(4)) dut_b (
      .clock(clock), .reset(reset), .dmem(if_b),
      .stat_reads(st_rd_b), .stat_stall_cycles(st_sc_b)
   );
   svc_rv_dmem_responder #(.AW(10), .MEM_TYPE(0), .STALL_CYCLES(3), .MISS_PERIOD(0)) dut_z (
      .clock(clock), .reset(reset), .dmem(if_z),
      .stat_reads(st_rd_z), .stat_stall_cycles(st_sc_z)
   );

   typedef struct {
      logic        ren;
      logic [31:0] raddr;
      logic        we;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        stall;
      logic [31:0] rs;
      logic [31:0] rb;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   z_stalls = 0;

   always @(negedge clock) begin
      if (if_z.dmem_stall !== 1'b0) z_stalls++;
   end

   function automatic vec_t mk(input logic ren, input logic [31:0] raddr, input logic we,
                               input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic stall,
                               input logic [31:0] rs, input logic [31:0] rb);
      vec_t v;
      v.ren = ren; v.raddr = raddr; v.we = we; v.waddr = waddr; v.wdata = wdata;
      v.wstrb = wstrb; v.stall = stall; v.rs = rs; v.rb = rb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; results are sampled on the falling edge.
   task automatic apply(input logic rst, input logic ren, input logic [31:0] raddr,
                        input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
      @(posedge clock);
      #1;
      reset = rst;
      if_s.dmem_ren = ren; if_s.dmem_raddr = raddr; if_s.dmem_we = we;
      if_s.dmem_waddr = waddr; if_s.dmem_wdata = wdata; if_s.dmem_wstrb = wstrb;
      if_b.dmem_ren = ren; if_b.dmem_raddr = raddr; if_b.dmem_we = we;
      if_b.dmem_waddr = waddr; if_b.dmem_wdata = wdata; if_b.dmem_wstrb = wstrb;
      if_z.dmem_ren = ren; if_z.dmem_raddr = raddr; if_z.dmem_we = we;
      if_z.dmem_waddr = waddr; if_z.dmem_wdata = wdata; if_z.dmem_wstrb = wstrb;
      @(negedge clock);
   endtask

   task automatic rd(input logic rst, input logic [31:0] a);
      apply(rst, 1'b1, a, 1'b0, 32'd0, 32'd0, 4'h0);
   endtask

   task automatic idle(input logic rst);
      apply(rst, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
   endtask

   task automatic expect3(input string tag, input logic st, input logic [31:0] rs,
                          input logic [31:0] rb);
      chk({tag, " stall_sram"}, 32'(if_s.dmem_stall), 32'(st));
      chk({tag, " stall_bram"}, 32'(if_b.dmem_stall), 32'(st));
      chk({tag, " rdata_sram"}, if_s.dmem_rdata, rs);
      chk({tag, " rdata_bram"}, if_b.dmem_rdata, rb);
   endtask

   task automatic expect_stats(input string tag, input logic [31:0] reads, input logic [31:0] stalls);
      chk({tag, " stat_reads_sram"}, st_rd_s, STATS ? reads : 32'd0);
      chk({tag, " stat_stall_sram"}, st_sc_s, STATS ? stalls : 32'd0);
      chk({tag, " stat_reads_bram"}, st_rd_b, STATS ? reads : 32'd0);
      chk({tag, " stat_stall_bram"}, st_sc_b, STATS ? stalls : 32'd0);
   endtask

   initial begin
      if_s.dmem_ren = 1'b0; if_s.dmem_raddr = '0; if_s.dmem_we = 1'b0;
      if_s.dmem_waddr = '0; if_s.dmem_wdata = '0; if_s.dmem_wstrb = '0;
      if_b.dmem_ren = 1'b0; if_b.dmem_raddr = '0; if_b.dmem_we = 1'b0;
      if_b.dmem_waddr = '0; if_b.dmem_wdata = '0; if_b.dmem_wstrb = '0;
      if_z.dmem_ren = 1'b0; if_z.dmem_raddr = '0; if_z.dmem_we = 1'b0;
      if_z.dmem_waddr = '0; if_z.dmem_wdata = '0; if_z.dmem_wstrb = '0;

      //                ren  raddr         we   waddr         wdata          strb  stall rs             rb
      tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h0,         32'h0));
      tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h10,       32'hDEADBEEF,  4'hF, 1'b0, 32'h0,         32'h0));
      tbl.push_back(mk(1'b1, 32'h10,       1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'hDEADBEEF,  32'h0));
      tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h20,       32'h11223344,  4'hF, 1'b0, 32'hDEADBEEF,  32'hDEADBEEF));
      tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h20,       32'hAABBCCDD,  4'h5, 1'b0, 32'hDEADBEEF,  32'hDEADBEEF));
      tbl.push_back(mk(1'b1, 32'h20,       1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h11BB33DD,  32'hDEADBEEF));
      tbl.push_back(mk(1'b0, 32'h0,        1'b1, 32'h4,        32'h0000005A,  4'hF, 1'b0, 32'h11BB33DD,  32'h11BB33DD));
      tbl.push_back(mk(1'b1, 32'h1004,     1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h0000005A,  32'h11BB33DD));
      tbl.push_back(mk(1'b1, 32'h7,        1'b1, 32'h4,        32'h00000077,  4'hF, 1'b0, 32'h0000005A,  32'h0000005A));
      tbl.push_back(mk(1'b1, 32'h10,       1'b1, 32'h20,       32'hAABBCCDD,  4'h0, 1'b1, 32'h0000005A,  32'h0000005A));
      tbl.push_back(mk(1'b1, 32'h20,       1'b1, 32'h10,       32'h12000000,  4'h8, 1'b1, 32'h0000005A,  32'h0000005A));
      tbl.push_back(mk(1'b1, 32'h4,        1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h00000077,  32'h0000005A));
      tbl.push_back(mk(1'b1, 32'h10,       1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h12ADBEEF,  32'h00000077));
      tbl.push_back(mk(1'b1, 32'h20,       1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'h11BB33DD,  32'h12ADBEEF));
      tbl.push_back(mk(1'b1, 32'h10,       1'b1, 32'h20,       32'hCAFEF00D,  4'hF, 1'b0, 32'h12ADBEEF,  32'h11BB33DD));
      tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         4'h0, 1'b1, 32'h12ADBEEF,  32'h12ADBEEF));
      tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         4'h0, 1'b1, 32'h12ADBEEF,  32'h12ADBEEF));
      tbl.push_back(mk(1'b1, 32'h20,       1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'hCAFEF00D,  32'h12ADBEEF));
      tbl.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         4'h0, 1'b0, 32'hCAFEF00D,  32'hCAFEF00D));

      idle(1'b1);
      idle(1'b1);
      for (int i = 0; i < tbl.size(); i++) begin
         apply(1'b0, tbl[i].ren, tbl[i].raddr, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb);
         expect3($sformatf("vec%0d", i), tbl[i].stall, tbl[i].rs, tbl[i].rb);
      end

      // Four back-to-back reads from reset: fourth misses, two stall cycles, stats 4/2.
      idle(1'b1);
      idle(1'b0);
      expect3("seqA reset", 1'b0, 32'h0, 32'h0);
      expect_stats("seqA reset", 32'd0, 32'd0);
      rd(1'b0, 32'h10);  expect3("seqA rd1", 1'b0, 32'h12ADBEEF, 32'h0);
      rd(1'b0, 32'h20);  expect3("seqA rd2", 1'b0, 32'hCAFEF00D, 32'h12ADBEEF);
      rd(1'b0, 32'h4);   expect3("seqA rd3", 1'b0, 32'h00000077, 32'hCAFEF00D);
      rd(1'b0, 32'h10);  expect3("seqA rd4", 1'b0, 32'h12ADBEEF, 32'h00000077);
      rd(1'b0, 32'h20);  expect3("seqA st1", 1'b1, 32'h12ADBEEF, 32'h12ADBEEF);
      rd(1'b0, 32'h4);   expect3("seqA st2", 1'b1, 32'h12ADBEEF, 32'h12ADBEEF);
      idle(1'b0);        expect3("seqA done", 1'b0, 32'h12ADBEEF, 32'h12ADBEEF);
      expect_stats("seqA", 32'd4, 32'd2);

      // Reset asserted in the first stall cycle drops the stall and clears the counter.
      rd(1'b0, 32'h4);   expect3("seqB rd1", 1'b0, 32'h00000077, 32'h12ADBEEF);
      rd(1'b0, 32'h10);  expect3("seqB rd2", 1'b0, 32'h12ADBEEF, 32'h00000077);
      rd(1'b0, 32'h20);  expect3("seqB rd3", 1'b0, 32'hCAFEF00D, 32'h12ADBEEF);
      rd(1'b0, 32'h4);   expect3("seqB rd4", 1'b0, 32'h00000077, 32'hCAFEF00D);
      idle(1'b1);        expect3("seqB st1", 1'b1, 32'h00000077, 32'h00000077);
      idle(1'b0);        expect3("seqB post", 1'b0, 32'h0, 32'h0);
      expect_stats("seqB post", 32'd0, 32'd0);
      rd(1'b0, 32'h20);  expect3("seqB rd5", 1'b0, 32'hCAFEF00D, 32'h0);
      rd(1'b0, 32'h10);  expect3("seqB rd6", 1'b0, 32'h12ADBEEF, 32'hCAFEF00D);
      rd(1'b0, 32'h4);   expect3("seqB rd7", 1'b0, 32'h00000077, 32'h12ADBEEF);
      idle(1'b0);        expect3("seqB done", 1'b0, 32'h00000077, 32'h00000077);

      // Two reads, reset, then three reads: none may stall if the miss counter was cleared.
      idle(1'b1);
      rd(1'b0, 32'h10);
      rd(1'b0, 32'h20);
      idle(1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) rd(1'b0, 32'h4);
         else idle(1'b0);
         chk($sformatf("seqC stall_sram %0d", i), 32'(if_s.dmem_stall), 32'd0);
         chk($sformatf("seqC stall_bram %0d", i), 32'(if_b.dmem_stall), 32'd0);
      end

      chk("never_miss stall cycles", 32'(z_stalls), 32'd0);
      chk("never_miss stat_stall", st_sc_z, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
